mem_arbiter: RTL

- Arbitrates the single-port data RAM (4096 x 32) between two requesters: the cpu core and the host/testbench port.
- Replaces the ad-hoc mutex steering in the processor top level.
- Sequences each access as issue, then optional read wait, then acknowledge.
- Provides round-robin fairness and a host-exclusive mode that blocks the cpu while the host inspects memory.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/rr_pick2.sv | 26 ++
 rtl/mem_arbiter.sv | 89 ++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions: access-type encoding, bus widths,
// arbiter state/owner encodings and the latched request payload.
package mem_pkg;

    localparam int unsigned BUSW  = 32;  // data bus width
    localparam int unsigned MINDW = 12;  // RAM word-index width (4096 words)

    localparam logic REN = 1'b0;
    localparam logic WEN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    // One requester's access as latched onto the RAM port.
    typedef struct packed {
        logic             rwen;
        logic [MINDW-1:0] addr;
        logic [BUSW-1:0]  wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the cpu port, host port and RAM port around mem_arbiter.
//   master : requesters + RAM model (drive requests and mem_rdata)
//   slave  : the arbiter (drives acks, read data, RAM address/data/enable)
interface mem_arbiter_if;
    import mem_pkg::*;

    logic             cpu_req;
    logic             cpu_rwen;
    logic [MINDW-1:0] cpu_addr;
    logic [BUSW-1:0]  cpu_wdata;
    logic             cpu_ack;
    logic [BUSW-1:0]  cpu_rdata;

    logic             host_req;
    logic             host_rwen;
    logic [MINDW-1:0] host_addr;
    logic [BUSW-1:0]  host_wdata;
    logic             host_ack;
    logic [BUSW-1:0]  host_rdata;
    logic             host_excl;

    logic             mem_rwen;
    logic [MINDW-1:0] mem_addr;
    logic [BUSW-1:0]  mem_wdata;
    logic [BUSW-1:0]  mem_rdata;

    logic             owner;

    modport master (
        output cpu_req, cpu_rwen, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output host_req, host_rwen, host_addr, host_wdata, host_excl,
        input  host_ack, host_rdata,
        input  mem_rwen, mem_addr, mem_wdata,
        output mem_rdata,
        input  owner
    );

    modport slave (
        input  cpu_req, cpu_rwen, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  host_req, host_rwen, host_addr, host_wdata, host_excl,
        output host_ack, host_rdata,
        output mem_rwen, mem_addr, mem_wdata,
        input  mem_rdata,
        output owner
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin pick.
//   elig_cpu/elig_host : eligible requests
//   rr_last            : previous winner (loses a tie)
//   grant_c            : at least one requester eligible
//   winner_c           : selected requester
module rr_pick2
    import mem_pkg::*;
(
    input  logic   elig_cpu,
    input  logic   elig_host,
    input  owner_t rr_last,
    output logic   grant_c,
    output owner_t winner_c
);

    always_comb begin
        grant_c  = elig_cpu | elig_host;
        winner_c = OWN_CPU;
        if (elig_cpu && elig_host) begin
            winner_c = (rr_last == OWN_HOST) ? OWN_CPU : OWN_HOST;
        end else if (elig_host) begin
            winner_c = OWN_HOST;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the cpu and the host port.
// Each access runs IDLE -> ISSUE (-> RDWAIT for reads) -> IDLE; the winner's
// request is latched onto mem_* at the IDLE->ISSUE edge. host_excl blocks
// new cpu grants without disturbing an access already in flight.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cpu/host request ports, RAM port and owner debug output
module mem_arbiter
    import mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_t state_q, state_d;
    owner_t     owner_q, owner_d;
    owner_t     rr_last_q, rr_last_d;
    mem_req_t   mem_q, mem_d;

    mem_req_t   cpu_r, host_r;
    logic       grant_c;
    owner_t     winner_c;
    logic       ack_phase_c;
    logic       rd_phase_c;

    assign cpu_r  = '{rwen: bus.cpu_rwen,  addr: bus.cpu_addr,  wdata: bus.cpu_wdata};
    assign host_r = '{rwen: bus.host_rwen, addr: bus.host_addr, wdata: bus.host_wdata};

    rr_pick2 u_pick (
        .elig_cpu  (bus.cpu_req && !bus.host_excl),
        .elig_host (bus.host_req),
        .rr_last   (rr_last_q),
        .grant_c   (grant_c),
        .winner_c  (winner_c)
    );

    // State and RAM-port registers; reset leaves rr_last on host so cpu wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_CPU;
            rr_last_q <= OWN_HOST;
            mem_q     <= '{rwen: REN, addr: '0, wdata: '0};
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            mem_q     <= mem_d;
        end
    end

    // Next state; mem_rwen falls back to REN so WEN lasts exactly one ISSUE cycle.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        mem_d     = mem_q;
        mem_d.rwen = REN;
        case (state_q)
            ST_IDLE: begin
                if (grant_c) begin
                    state_d   = ST_ISSUE;
                    owner_d   = winner_c;
                    rr_last_d = winner_c;
                    mem_d     = (winner_c == OWN_HOST) ? host_r : cpu_r;
                end
            end
            ST_ISSUE:  state_d = (mem_q.rwen == WEN) ? ST_IDLE : ST_RDWAIT;
            ST_RDWAIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Acks decode the current state; suppressed while rst is high so an abandoned access never acks.
    assign ack_phase_c = !rst && (((state_q == ST_ISSUE) && (mem_q.rwen == WEN)) ||
                                  (state_q == ST_RDWAIT));
    assign rd_phase_c  = !rst && (state_q == ST_RDWAIT);

    assign bus.cpu_ack    = ack_phase_c && (owner_q == OWN_CPU);
    assign bus.host_ack   = ack_phase_c && (owner_q == OWN_HOST);
    assign bus.cpu_rdata  = (rd_phase_c && (owner_q == OWN_CPU))  ? bus.mem_rdata : '0;
    assign bus.host_rdata = (rd_phase_c && (owner_q == OWN_HOST)) ? bus.mem_rdata : '0;

    assign bus.mem_rwen  = mem_q.rwen;
    assign bus.mem_addr  = mem_q.addr;
    assign bus.mem_wdata = mem_q.wdata;
    assign bus.owner     = owner_q;

endmodule
